// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM encodings, instruction width, NOP and
// the major opcodes decoded by control_unit.
package cpu_defs_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that arrives while decode is stalled.
// Load takes effect next cycle; clear beats drain beats load for the full flag.
module fetch_skid_buf #(
    parameter int PC_W = 64,
    parameter int IW   = cpu_defs_pkg::INSTR_W
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [IW-1:0]   instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [IW-1:0]   instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic            full_o
);

    logic            full_q;
    logic [IW-1:0]   instr_q;
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            if (clear_i || drain_i) begin
                full_q <= 1'b0;
            end else if (load_i) begin
                full_q <= 1'b1;
            end
            if (load_i) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign full_o  = full_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem request/response, IF/ID register, redirect flush and stall skid.
// IF/ID loads 1 cycle after rsp_valid; a stalled response parks in the skid and blocks new requests.
module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = cpu_defs_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               stall,
    input  logic               branch,
    input  logic               zero_flag,
    input  logic               jump,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [PC_W-1:0]    jump_target,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [6:0]         opcode
);
    import cpu_defs_pkg::*;

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                kill_q, kill_d;
    logic                ifv_q, ifv_d;
    logic [INSTR_W-1:0]  ifi_q, ifi_d;
    logic [PC_W-1:0]     ifpc_q, ifpc_d;

    logic                skid_load, skid_drain, skid_clear, skid_full;
    logic [INSTR_W-1:0]  skid_instr;
    logic [PC_W-1:0]     skid_pc;

    logic                redir;
    logic [PC_W-1:0]     redir_tgt;
    logic [PC_W-1:0]     pc_inc;

    assign redir     = jump | (branch & zero_flag);
    assign redir_tgt = (jump ? jump_target : branch_target) & ~PC_W'(3);
    assign pc_inc    = pc_q + PC_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        // Decode consumes IF/ID every unstalled cycle, so it empties unless reloaded.
        ifv_d      = stall ? ifv_q : 1'b0;
        ifi_d      = stall ? ifi_q : '0;
        ifpc_d     = ifpc_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    if (redir) kill_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redir) begin
                        if (!stall) begin
                            ifv_d  = 1'b1;
                            ifi_d  = imem_rsp_data;
                            ifpc_d = pc_q;
                            pc_d   = pc_inc;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    skid_clear = 1'b1;
                    state_d    = ST_REQ;
                end else if (!stall && skid_full) begin
                    skid_drain = 1'b1;
                    ifv_d      = 1'b1;
                    ifi_d      = skid_instr;
                    ifpc_d     = skid_pc;
                    pc_d       = pc_inc;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redir) begin
            pc_d  = redir_tgt;
            ifv_d = 1'b0;
            ifi_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            ifv_q   <= 1'b0;
            ifi_q   <= '0;
            ifpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            ifv_q   <= ifv_d;
            ifi_q   <= ifi_d;
            ifpc_q  <= ifpc_d;
        end
    end

    fetch_skid_buf #(.PC_W(PC_W), .IW(INSTR_W)) u_skid (
        .clk     (clk),
        .arst_n  (arst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (imem_rsp_data),
        .pc_i    (pc_q),
        .instr_o (skid_instr),
        .pc_o    (skid_pc),
        .full_o  (skid_full)
    );

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign if_id_valid    = ifv_q;
    assign if_id_instr    = ifi_q;
    assign if_id_pc       = ifpc_q;
    assign opcode         = ifi_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1- or 2-cycle-latency instruction memory.
module tb_instr_fetch_unit;
    import cpu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        stall, branch, zero_flag, jump;
    logic [63:0] branch_target, jump_target;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic [6:0]  opcode;

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 1;
    logic        p_vld  = 1'b0;
    logic [63:0] p_addr = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .stall          (stall),
        .branch         (branch),
        .zero_flag      (zero_flag),
        .jump           (jump),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .opcode         (opcode)
    );

    // addi x(k[4:0]), x0, k with k = word index; addr 0 -> NOP, addr 4 -> 00100093
    function automatic logic [31:0] word(input logic [63:0] a);
        logic [11:0] k;
        k = a[13:2];
        return {k, 5'd0, 3'd0, k[4:0], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One clock; the memory model answers accepted requests after lat cycles.
    task automatic tick();
        logic        a;
        logic [63:0] ad;
        a  = imem_req_valid && imem_req_ready;
        ad = imem_req_addr;
        @(posedge clk); #1;
        if (lat == 1) begin
            imem_rsp_valid = a;
            imem_rsp_data  = word(ad);
        end else begin
            imem_rsp_valid = p_vld;
            imem_rsp_data  = word(p_addr);
            p_vld  = a;
            p_addr = ad;
        end
    endtask

    task automatic check_ifid(input string tag, input logic [63:0] pc);
        check({tag, "_vld"}, 64'(if_id_valid), 64'd1);
        check({tag, "_pc"}, if_id_pc, pc);
        check({tag, "_instr"}, 64'(if_id_instr), 64'(word(pc)));
    endtask

    task automatic check_req(input string tag, input logic [63:0] addr);
        check({tag, "_rvld"}, 64'(imem_req_valid), 64'd1);
        check({tag, "_raddr"}, imem_req_addr, addr);
    endtask

    task automatic check_flushed(input string tag);
        check({tag, "_vld"}, 64'(if_id_valid), 64'd0);
        check({tag, "_instr"}, 64'(if_id_instr), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; stall = 1'b0; branch = 1'b0; zero_flag = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #2;
        check("rst_rvld", 64'(imem_req_valid), 64'd0);
        check_flushed("rst");
        check("rst_pc", if_id_pc, 64'd0);
        check("rst_op", 64'(opcode), 64'd0);
        #10 arst_n = 1'b1;

        // 1: sequential fetch
        tick();
        check_req("t1_a0", 64'h0);
        tick();
        check("t1_wait_vld", 64'(if_id_valid), 64'd0);
        tick();
        check_ifid("t1_if0", 64'h0);
        check("t1_nop", 64'(if_id_instr), 64'(NOP_INSTR));
        check("t1_op", 64'(opcode), 64'(OP_IMM));
        check_req("t1_a4", 64'h4);
        tick();
        check("t1_bubble", 64'(if_id_valid), 64'd0);
        tick();
        check_ifid("t1_if4", 64'h4);
        check("t1_w4", 64'(if_id_instr), 64'h0010_0093);
        check_req("t1_a8", 64'h8);

        // 2: stall while addr 8 returns
        stall = 1'b1;
        tick();
        check_ifid("t2_hold0", 64'h4);
        tick();
        check("t2_hold_rvld", 64'(imem_req_valid), 64'd0);
        check_ifid("t2_hold1", 64'h4);
        tick();
        check("t2_hold2_rvld", 64'(imem_req_valid), 64'd0);
        check_ifid("t2_hold2", 64'h4);
        stall = 1'b0;
        tick();
        check_ifid("t2_if8", 64'h8);
        check_req("t2_a12", 64'hc);

        // 3: taken branch while in WAIT, response dropped
        tick();
        branch = 1'b1; zero_flag = 1'b1; branch_target = 64'h40;
        tick();
        check_flushed("t3");
        check_req("t3_a40", 64'h40);
        branch = 1'b0; zero_flag = 1'b0;

        // 4: not-taken branch
        branch = 1'b1;
        tick();
        tick();
        check_ifid("t4_if40", 64'h40);
        check_req("t4_a44", 64'h44);
        branch = 1'b0;

        // 5: jump beats branch, in-flight fetch killed
        jump = 1'b1; jump_target = 64'h100;
        branch = 1'b1; zero_flag = 1'b1; branch_target = 64'h40;
        tick();
        check("t5_wait_rvld", 64'(imem_req_valid), 64'd0);
        check_flushed("t5a");
        jump = 1'b0; branch = 1'b0; zero_flag = 1'b0;
        tick();
        check_flushed("t5b");
        check_req("t5_a100", 64'h100);
        tick();
        tick();
        check_ifid("t5_if100", 64'h100);
        check_req("t5_a104", 64'h104);

        // 6: redirect in HOLD under stall, target low bits cleared
        stall = 1'b1;
        tick();
        tick();
        check("t6_hold_rvld", 64'(imem_req_valid), 64'd0);
        check_ifid("t6_hold", 64'h100);
        branch = 1'b1; zero_flag = 1'b1; branch_target = 64'h81;
        tick();
        check_flushed("t6");
        check_req("t6_a80", 64'h80);
        branch = 1'b0; zero_flag = 1'b0; stall = 1'b0;
        tick();
        tick();
        check_ifid("t6_if80", 64'h80);
        check_req("t6_a84", 64'h84);

        // kill with a slow memory: response arrives after the redirect
        lat = 2;
        tick();
        jump = 1'b1; jump_target = 64'h200;
        tick();
        check("tk_wait_rvld", 64'(imem_req_valid), 64'd0);
        check_flushed("tk_a");
        jump = 1'b0;
        tick();
        check_flushed("tk_b");
        check_req("tk_a200", 64'h200);
        lat = 1;
        tick();
        tick();
        check_ifid("tk_if200", 64'h200);

        // pc+4 wraps at the top of the address space
        jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        jump = 1'b0;
        tick();
        check_req("tw_top", 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        check_ifid("tw_iftop", 64'hFFFF_FFFF_FFFF_FFFC);
        check_req("tw_a0", 64'h0);

        // 7: async reset in WAIT
        tick();
        arst_n = 1'b0;
        #1;
        check("t7_rvld", 64'(imem_req_valid), 64'd0);
        check_flushed("t7");
        check("t7_pc", if_id_pc, 64'd0);
        check("t7_op", 64'(opcode), 64'd0);
        tick();
        #2 arst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
        check_req("t7_a0", 64'h0);
        check("t7_late_vld", 64'(if_id_valid), 64'd0);
        tick();
        tick();
        check_ifid("t7_if0", 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
